// File: rtl/color_pkg.sv
// Shared definitions for the sticker colour emitter: colour codes, FSM encoding
// and the code-to-level lookup used by the display path.
package color_pkg;

    localparam int FACE_SLOTS = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    localparam logic [2:0] COL_W    = 3'd0;
    localparam logic [2:0] COL_O    = 3'd1;
    localparam logic [2:0] COL_G    = 3'd2;
    localparam logic [2:0] COL_RED  = 3'd3;
    localparam logic [2:0] COL_BLUE = 3'd4;
    localparam logic [2:0] COL_Y    = 3'd5;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } level_t;

    localparam level_t LVL_W    = '{r: 4'd8, g: 4'd8, b: 4'd8};
    localparam level_t LVL_O    = '{r: 4'd8, g: 4'd3, b: 4'd0};
    localparam level_t LVL_G    = '{r: 4'd0, g: 4'd8, b: 4'd0};
    localparam level_t LVL_RED  = '{r: 4'd6, g: 4'd0, b: 4'd0};
    localparam level_t LVL_BLUE = '{r: 4'd0, g: 4'd0, b: 4'd8};
    localparam level_t LVL_Y    = '{r: 4'd8, g: 4'd8, b: 4'd0};
    localparam level_t LVL_OFF  = '{r: 4'd0, g: 4'd0, b: 4'd0};

    // Codes 6 and 7 are not colours; they display as dark.
    function automatic level_t color_level(input logic [2:0] code);
        level_t lvl;
        case (code)
            COL_W:    lvl = LVL_W;
            COL_O:    lvl = LVL_O;
            COL_G:    lvl = LVL_G;
            COL_RED:  lvl = LVL_RED;
            COL_BLUE: lvl = LVL_BLUE;
            COL_Y:    lvl = LVL_Y;
            default:  lvl = LVL_OFF;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/color_emitter_if.sv
// Colour-code input channel: valid/ready transfer plus the face discard request.
interface color_emitter_if;
    logic [2:0] color_in;
    logic       color_valid;
    logic       color_ready;
    logic       face_clear;

    modport master (
        output color_in,
        output color_valid,
        output face_clear,
        input  color_ready
    );

    modport slave (
        input  color_in,
        input  color_valid,
        input  face_clear,
        output color_ready
    );
endinterface

// File: rtl/color_pwm.sv
// Free-running 16-step PWM turning the three 4-bit sticker levels into LED drives.
module color_pwm
    import color_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  level_t level,
    output logic   led_r,
    output logic   led_g,
    output logic   led_b
);

    logic [3:0] pwm_cnt_q;
    logic [3:0] pwm_cnt_d;

    always_comb pwm_cnt_d = pwm_cnt_q + 4'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pwm_cnt_q <= '0;
        else          pwm_cnt_q <= pwm_cnt_d;
    end

    assign led_r = (pwm_cnt_q < level.r);
    assign led_g = (pwm_cnt_q < level.g);
    assign led_b = (pwm_cnt_q < level.b);

endmodule

// File: rtl/color_emitter.sv
// Collects a 9-sticker face over a valid/ready channel, then cycles through it,
// presenting each sticker's colour as registered levels and PWM LED drives.
module color_emitter
    import color_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000,
    parameter int FACE_SIZE   = FACE_SLOTS
) (
    input  logic            clock,
    input  logic            reset_n,
    color_emitter_if.slave  bus,
    output logic [7:0]      red,
    output logic [7:0]      green,
    output logic [7:0]      blue,
    output logic            led_r,
    output logic            led_g,
    output logic            led_b,
    output logic [3:0]      sticker_idx,
    output logic            frame_wrap
);

    localparam int             HW        = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [3:0]     LAST_SLOT = 4'(FACE_SIZE - 1);

    state_t        state_q, state_d;
    logic [2:0]    buf_q [FACE_SIZE];
    logic [2:0]    buf_d [FACE_SIZE];
    logic [3:0]    fill_q, fill_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    idx_q, idx_d;
    level_t        lvl_q, lvl_d;
    logic          ready_q, ready_d;
    logic          wrap_q, wrap_d;
    logic          xfer;
    logic          advance;

    // A simultaneous discard request wins, so the colliding code is never stored.
    assign xfer    = bus.color_valid & ready_q & ~bus.face_clear;
    assign advance = (state_q == ST_SHOW) && (hold_q == HOLD_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (xfer) state_d = ST_LOAD;
            ST_LOAD: begin
                if (bus.face_clear)                   state_d = ST_IDLE;
                else if (xfer && fill_q == LAST_SLOT) state_d = ST_SHOW;
            end
            ST_SHOW: if (bus.face_clear) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fill_d  = fill_q;
        hold_d  = '0;
        idx_d   = '0;
        wrap_d  = 1'b0;
        lvl_d   = LVL_OFF;
        ready_d = (state_d != ST_SHOW);

        if (state_d == ST_IDLE) fill_d = '0;
        else if (xfer)          fill_d = fill_q + 4'd1;

        // Levels lag the index by one cycle and are forced dark on the exit edge.
        if (state_q == ST_SHOW && state_d == ST_SHOW) begin
            lvl_d = color_level(buf_q[idx_q]);
            if (advance) begin
                wrap_d = (idx_q == LAST_SLOT);
                idx_d  = (idx_q == LAST_SLOT) ? 4'd0 : idx_q + 4'd1;
            end else begin
                hold_d = hold_q + 1'b1;
                idx_d  = idx_q;
            end
        end
    end

    for (genvar gi = 0; gi < FACE_SIZE; gi++) begin : g_slot
        assign buf_d[gi] = (xfer && fill_q == 4'(gi)) ? bus.color_in : buf_q[gi];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) buf_q[gi] <= '0;
            else          buf_q[gi] <= buf_d[gi];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_q  <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            lvl_q   <= LVL_OFF;
            ready_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            lvl_q   <= lvl_d;
            ready_q <= ready_d;
            wrap_q  <= wrap_d;
        end
    end

    color_pwm u_pwm (
        .clock   (clock),
        .reset_n (reset_n),
        .level   (lvl_q),
        .led_r   (led_r),
        .led_g   (led_g),
        .led_b   (led_b)
    );

    assign bus.color_ready = ready_q;
    assign red             = {4'b0000, lvl_q.r};
    assign green           = {4'b0000, lvl_q.g};
    assign blue            = {4'b0000, lvl_q.b};
    assign sticker_idx     = idx_q;
    assign frame_wrap      = wrap_q;

endmodule

// File: tb/tb_color_emitter.sv
// Scoreboard bench: the stimulus pushes the expected sticker presentations of each
// face; a monitor pops one per displayed sticker and also checks hold time and LED duty.
module tb_color_emitter;

    localparam int HOLD = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] red, green, blue;
    logic       led_r, led_g, led_b;
    logic [3:0] sticker_idx;
    logic       frame_wrap;

    always #5 clock = ~clock;

    color_emitter_if bus ();

    color_emitter #(.HOLD_CYCLES(HOLD), .FACE_SIZE(9)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .led_r       (led_r),
        .led_g       (led_g),
        .led_b       (led_b),
        .sticker_idx (sticker_idx),
        .frame_wrap  (frame_wrap)
    );

    // Reference colour table indexed by code; codes 6 and 7 are dark.
    int lut_r [8] = '{8, 8, 0, 6, 0, 8, 0, 0};
    int lut_g [8] = '{8, 3, 8, 0, 0, 8, 0, 0};
    int lut_b [8] = '{8, 0, 0, 0, 8, 0, 0, 0};

    typedef struct {
        int idx;
        int r;
        int g;
        int b;
        bit wrap;
    } pres_t;

    pres_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input bit ok, input string detail);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Expected sequence: sticker k shows slot k mod 9; every return to slot 0 is a wrap.
    task automatic push_face(input int codes[9], input int n);
        pres_t p;
        for (int k = 0; k < n; k++) begin
            p.idx  = k % 9;
            p.r    = lut_r[codes[k % 9]];
            p.g    = lut_g[codes[k % 9]];
            p.b    = lut_b[codes[k % 9]];
            p.wrap = (k > 0) && (k % 9 == 0);
            sb.push_back(p);
        end
    endtask

    task automatic send(input int code);
        int t;
        t = 0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        while (!bus.color_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) check("ready_timeout", 1'b0, "color_ready stayed 0, want 1");
        bus.color_valid = 1'b1;
        bus.color_in    = 3'(code);
        @(negedge clock);
        bus.color_valid = 1'b0;
        bus.color_in    = 3'($urandom_range(0, 7));
    endtask

    task automatic load_face(input int codes[9]);
        for (int i = 0; i < 9; i++) send(codes[i]);
        check("ready_low_after_9th", bus.color_ready == 1'b0,
              $sformatf("color_ready=%b, want 0", bus.color_ready));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < HOLD * 15) begin
            @(negedge clock);
            t++;
        end
        check("drain", sb.size() == 0,
              $sformatf("%0d presentations outstanding, want 0", sb.size()));
    endtask

    task automatic clear_face(input bit with_valid);
        @(negedge clock);
        bus.face_clear  = 1'b1;
        bus.color_valid = with_valid;
        bus.color_in    = 3'($urandom_range(0, 7));
        @(negedge clock);
        bus.face_clear  = 1'b0;
        bus.color_valid = 1'b0;
        check("clear_to_idle",
              bus.color_ready && sticker_idx == 4'd0 && red == 8'd0 && green == 8'd0 &&
              blue == 8'd0 && {led_r, led_g, led_b} == 3'b000 && !frame_wrap,
              $sformatf("ready=%b idx=%0d rgb=(%0d,%0d,%0d) leds=%b%b%b, want ready=1 rest 0",
                        bus.color_ready, sticker_idx, red, green, blue, led_r, led_g, led_b));
    endtask

    task automatic check_all_zero(input string name);
        check(name,
              red == 8'd0 && green == 8'd0 && blue == 8'd0 && {led_r, led_g, led_b} == 3'b000 &&
              sticker_idx == 4'd0 && !frame_wrap && !bus.color_ready,
              $sformatf("rgb=(%0d,%0d,%0d) leds=%b%b%b idx=%0d wrap=%b ready=%b, want all 0",
                        red, green, blue, led_r, led_g, led_b, sticker_idx, frame_wrap,
                        bus.color_ready));
    endtask

    // Monitor: a presentation is the first cycle after the index moves (or SHOW is entered).
    initial begin : monitor
        bit         ready_prev, armed, wrap_arm, win;
        logic [3:0] idx_prev;
        int         cyc, last_t, win_len, cr, cg, cb, er, eg, eb;
        pres_t      p;
        ready_prev = 1'b0; armed = 1'b0; wrap_arm = 1'b0; win = 1'b0;
        idx_prev = '0; cyc = 0; last_t = -1; win_len = 0;
        cr = 0; cg = 0; cb = 0; er = 0; eg = 0; eb = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                armed = 1'b0; win = 1'b0; last_t = -1; ready_prev = 1'b0; idx_prev = '0;
            end else begin
                if (armed) begin
                    armed = 1'b0;
                    if (win && win_len == HOLD)
                        check("led_duty", cr == er && cg == eg && cb == eb,
                              $sformatf("high counts (%0d,%0d,%0d) over %0d cycles, want (%0d,%0d,%0d)",
                                        cr, cg, cb, HOLD, er, eg, eb));
                    if (last_t >= 0)
                        check("hold_time", cyc - last_t == HOLD,
                              $sformatf("sticker held %0d cycles, want %0d", cyc - last_t, HOLD));
                    last_t = cyc;
                    win = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_present", 1'b0,
                              $sformatf("idx=%0d shown with no expectation queued", sticker_idx));
                    end else begin
                        p = sb.pop_front();
                        $display("present idx=%0d rgb=(%0d,%0d,%0d) wrap=%b", sticker_idx,
                                 red, green, blue, wrap_arm);
                        check("present",
                              int'(sticker_idx) == p.idx && int'(red) == p.r &&
                              int'(green) == p.g && int'(blue) == p.b && wrap_arm == p.wrap,
                              $sformatf("idx=%0d rgb=(%0d,%0d,%0d) wrap=%b, want idx=%0d rgb=(%0d,%0d,%0d) wrap=%b",
                                        sticker_idx, red, green, blue, wrap_arm,
                                        p.idx, p.r, p.g, p.b, p.wrap));
                        win = 1'b1; win_len = 0; cr = 0; cg = 0; cb = 0;
                        er = p.r; eg = p.g; eb = p.b;
                    end
                end
                if (!bus.color_ready && (ready_prev || sticker_idx != idx_prev)) begin
                    armed    = 1'b1;
                    wrap_arm = frame_wrap;
                end else if (frame_wrap) begin
                    check("stray_wrap", 1'b0, "frame_wrap=1 without an index change, want 0");
                end
                if (bus.color_ready) begin
                    win = 1'b0;
                    last_t = -1;
                end
                if (win) begin
                    win_len++;
                    cr += int'(led_r);
                    cg += int'(led_g);
                    cb += int'(led_b);
                end
                ready_prev = bus.color_ready;
                idx_prev   = sticker_idx;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int face[9];
        bus.color_in    = 3'd0;
        bus.color_valid = 1'b0;
        bus.face_clear  = 1'b0;

        repeat (3) @(negedge clock);
        check_all_zero("reset_state");
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_reset", bus.color_ready == 1'b1,
              $sformatf("color_ready=%b, want 1", bus.color_ready));

        // Known face covering every colour, run past one wrap.
        face = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
        push_face(face, 11);
        load_face(face);
        wait_drain();
        clear_face(1'b0);

        // Discard a partial face with a colliding transfer, then load afresh.
        for (int i = 0; i < 4; i++) send($urandom_range(0, 5));
        clear_face(1'b1);
        for (int i = 0; i < 9; i++) face[i] = $urandom_range(0, 7);
        push_face(face, 10);
        load_face(face);
        wait_drain();
        clear_face(1'b0);

        // Invalid code first, then pure blue.
        for (int i = 0; i < 9; i++) face[i] = $urandom_range(0, 7);
        face[0] = 6;
        face[1] = 4;
        push_face(face, 10);
        load_face(face);
        wait_drain();
        clear_face(1'b0);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 9; i++) face[i] = $urandom_range(0, 7);
            push_face(face, $urandom_range(9, 12));
            load_face(face);
            wait_drain();
            clear_face(1'b0);
        end

        // Asynchronous reset in the middle of a sticker hold.
        for (int i = 0; i < 9; i++) face[i] = $urandom_range(0, 5);
        push_face(face, 3);
        load_face(face);
        wait_drain();
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_release", bus.color_ready == 1'b1,
              $sformatf("color_ready=%b, want 1", bus.color_ready));

        for (int i = 0; i < 9; i++) face[i] = $urandom_range(0, 7);
        push_face(face, 10);
        load_face(face);
        wait_drain();
        clear_face(1'b0);

        repeat (4) @(negedge clock);
        check("scoreboard_empty", sb.size() == 0,
              $sformatf("%0d left, want 0", sb.size()));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
